// File: rtl/vx_csr_regfile_pkg.sv
// Shared CSR definitions: op encoding, address map, decode bundle, RMW helper.
// Imported by the decoder, the register file top and the testbench.
package vx_csr_regfile_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [2:0] {
        K_FFLAGS  = 3'd0,
        K_FRM     = 3'd1,
        K_FCSR    = 3'd2,
        K_SCRATCH = 3'd3,
        K_CTR     = 3'd4,
        K_CYCLE   = 3'd5,
        K_CONST   = 3'd6
    } csr_kind_e;

    localparam int IDX_W = 7;

    localparam logic [11:0] CSR_FFLAGS       = 12'h001;
    localparam logic [11:0] CSR_FRM          = 12'h002;
    localparam logic [11:0] CSR_FCSR         = 12'h003;
    localparam logic [11:0] CSR_SCRATCH_BASE = 12'h340;
    localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
    localparam logic [11:0] CSR_CTR_BASE     = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
    localparam logic [11:0] CSR_CTR_H_BASE   = 12'hB83;
    localparam logic [11:0] CSR_WARP_ID      = 12'hCC1;
    localparam logic [11:0] CSR_MVENDORID    = 12'hF11;
    localparam logic [11:0] CSR_NUM_WARPS    = 12'hFC1;
    // lo and hi counter addresses differ only in bit 7
    localparam logic [11:0] CSR_HI_OFS       = 12'h080;

    // K_CONST index: 0 vendor id, 1 warp id, 2 warp count
    typedef struct packed {
        logic             valid;
        logic             read_only;
        csr_kind_e        kind;
        logic [IDX_W-1:0] index;
        logic             hi;
    } csr_decode_t;

    function automatic logic [63:0] csr_rmw(input csr_op_e op,
                                            input logic [63:0] old,
                                            input logic [63:0] d);
        logic [63:0] r;
        unique case (op)
            CSR_WRITE: r = d;
            CSR_SET:   r = old | d;
            CSR_CLEAR: r = old & ~d;
            default:   r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vx_csr_regfile_if.sv
// CSR request/response handshake bundle.
// master = issuing SFU side, slave = CSR register file.
interface vx_csr_regfile_if #(
    parameter int NUM_WARPS = 4,
    parameter int XLEN      = 32
);
    localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic            req_valid;
    logic            req_ready;
    logic [NW_W-1:0] req_wid;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_data;
    logic [1:0]      req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_error;

    modport master (
        output req_valid, req_wid, req_addr, req_data, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_wid, req_addr, req_data, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );

endinterface

// File: rtl/vx_csr_regfile_decode.sv
// Combinational CSR address decoder: addr -> csr_decode_t.
// Ports: addr (12b CSR number) in, dec (decode bundle) out.
module vx_csr_regfile_decode
    import vx_csr_regfile_pkg::*;
#(
    parameter int NUM_SCRATCH = 2,
    parameter int NUM_CTRS    = 4,
    parameter int XLEN        = 32
) (
    input  logic [11:0] addr,
    output csr_decode_t dec
);
    logic [11:0] scr_ofs, lo_ofs, hi_ofs;
    logic        is_scr, is_lo, is_hi;

    assign scr_ofs = addr - CSR_SCRATCH_BASE;
    assign lo_ofs  = addr - CSR_CTR_BASE;
    assign hi_ofs  = addr - CSR_CTR_H_BASE;
    assign is_scr  = scr_ofs < 12'(NUM_SCRATCH);
    assign is_lo   = lo_ofs < 12'(NUM_CTRS);
    assign is_hi   = hi_ofs < 12'(NUM_CTRS);

    always_comb begin
        dec      = '0;
        dec.kind = K_FFLAGS;
        unique case (1'b1)
            addr == CSR_FFLAGS: begin
                dec.valid = 1'b1;
            end
            addr == CSR_FRM: begin
                dec.valid = 1'b1;
                dec.kind  = K_FRM;
            end
            addr == CSR_FCSR: begin
                dec.valid = 1'b1;
                dec.kind  = K_FCSR;
            end
            is_scr: begin
                dec.valid = 1'b1;
                dec.kind  = K_SCRATCH;
                dec.index = IDX_W'(scr_ofs);
            end
            is_lo: begin
                dec.valid = 1'b1;
                dec.kind  = K_CTR;
                dec.index = IDX_W'(lo_ofs);
            end
            is_hi: begin
                // hi halves only exist on 32-bit harts
                dec.valid = (XLEN == 32);
                dec.kind  = K_CTR;
                dec.index = IDX_W'(hi_ofs);
                dec.hi    = 1'b1;
            end
            addr == CSR_MCYCLE: begin
                dec.valid     = 1'b1;
                dec.read_only = 1'b1;
                dec.kind      = K_CYCLE;
            end
            addr == CSR_MCYCLEH: begin
                dec.valid     = (XLEN == 32);
                dec.read_only = 1'b1;
                dec.kind      = K_CYCLE;
                dec.hi        = 1'b1;
            end
            addr == CSR_MVENDORID: begin
                dec.valid     = 1'b1;
                dec.read_only = 1'b1;
                dec.kind      = K_CONST;
            end
            addr == CSR_WARP_ID: begin
                dec.valid     = 1'b1;
                dec.read_only = 1'b1;
                dec.kind      = K_CONST;
                dec.index     = IDX_W'(1);
            end
            addr == CSR_NUM_WARPS: begin
                dec.valid     = 1'b1;
                dec.read_only = 1'b1;
                dec.kind      = K_CONST;
                dec.index     = IDX_W'(2);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vx_csr_regfile.sv
// Per-warp CSR register file: fcsr, scratch, shared 64-bit event counters.
// Ports: clk/reset, startup_arg, cycles, fpu_* flag/frm ports, ctr_incr, csr_if (slave).
module vx_csr_regfile
    import vx_csr_regfile_pkg::*;
#(
    parameter int NUM_WARPS     = 4,
    parameter int XLEN          = 32,
    parameter int NUM_SCRATCH   = 2,
    parameter int NUM_FPU_PORTS = 2,
    parameter int NUM_CTRS      = 4,
    parameter int CTR_BITS      = 44,
    localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [XLEN-1:0]                     startup_arg,
    input  logic [CTR_BITS-1:0]                 cycles,
    input  logic [NUM_FPU_PORTS-1:0]            fpu_valid,
    input  logic [NUM_FPU_PORTS-1:0][NW_W-1:0]  fpu_wid,
    input  logic [NUM_FPU_PORTS-1:0][4:0]       fpu_fflags,
    input  logic [NUM_FPU_PORTS-1:0][NW_W-1:0]  fpu_read_wid,
    output logic [NUM_FPU_PORTS-1:0][2:0]       fpu_read_frm,
    input  logic [NUM_CTRS-1:0]                 ctr_incr,
    vx_csr_regfile_if.slave                     csr_if
);
    csr_decode_t         dec;
    logic [7:0]          fcsr_q [NUM_WARPS];
    logic [7:0]          fcsr_d [NUM_WARPS];
    logic [XLEN-1:0]     scratch_q [NUM_WARPS][NUM_SCRATCH];
    logic [CTR_BITS-1:0] ctr_q [NUM_CTRS];
    logic [31:0]         shadow_q [NUM_WARPS];
    logic [11:0]         shadow_tag_q [NUM_WARPS];
    logic [NUM_WARPS-1:0] shadow_vld_q;
    logic                rsp_valid_q, rsp_error_q;
    logic [XLEN-1:0]     rsp_data_q;

    logic [NW_W-1:0] wid;
    csr_op_e         op;
    logic [63:0]     d64, full64, old, rsp_old, new_val, ctr_wr;
    logic            fire, ctr_sel, shadow_hit, write_req, err, commit;

    vx_csr_regfile_decode #(
        .NUM_SCRATCH (NUM_SCRATCH),
        .NUM_CTRS    (NUM_CTRS),
        .XLEN        (XLEN)
    ) u_decode (
        .addr (csr_if.req_addr),
        .dec  (dec)
    );

    assign wid     = csr_if.req_wid;
    assign op      = csr_op_e'(csr_if.req_op);
    assign d64     = 64'(csr_if.req_data);
    assign fire    = csr_if.req_valid & csr_if.req_ready;
    assign ctr_sel = (dec.kind == K_CTR) || (dec.kind == K_CYCLE);

    always_comb begin
        full64 = '0;
        old    = '0;
        unique case (dec.kind)
            K_FFLAGS:  old = 64'(fcsr_q[wid][4:0]);
            K_FRM:     old = 64'(fcsr_q[wid][7:5]);
            K_FCSR:    old = 64'(fcsr_q[wid]);
            K_SCRATCH: begin
                for (int k = 0; k < NUM_SCRATCH; k++)
                    if (dec.index == IDX_W'(k))
                        old = 64'(scratch_q[wid][k]);
            end
            K_CTR: begin
                for (int k = 0; k < NUM_CTRS; k++)
                    if (dec.index == IDX_W'(k))
                        full64 = 64'(ctr_q[k]);
            end
            K_CYCLE:   full64 = 64'(cycles);
            K_CONST: begin
                if (dec.index == IDX_W'(1))
                    old = 64'(wid);
                else if (dec.index == IDX_W'(2))
                    old = 64'(NUM_WARPS);
            end
            default: ;
        endcase
        if (ctr_sel)
            old = (XLEN == 32 && dec.hi) ? (full64 >> 32) : full64;
    end

    // a hi read right after a lo read of the same counter returns the
    // upper half captured with the lo read, so 32-bit software sees a
    // coherent 64-bit value
    assign shadow_hit = ctr_sel && dec.hi && shadow_vld_q[wid]
                        && (shadow_tag_q[wid] == csr_if.req_addr);
    assign rsp_old    = shadow_hit ? {32'b0, shadow_q[wid]} : old;

    // SET/CLEAR of zero is a pure read and may target read-only CSRs
    assign write_req = (op == CSR_WRITE) || ((op != CSR_READ) && (d64 != '0));
    assign err       = !dec.valid || (write_req && dec.read_only);
    assign new_val   = csr_rmw(op, old, d64);
    assign commit    = fire && !err && write_req;

    always_comb begin
        if (XLEN == 64)
            ctr_wr = new_val;
        else if (dec.hi)
            ctr_wr = {new_val[31:0], full64[31:0]};
        else
            ctr_wr = {full64[63:32], new_val[31:0]};
    end

    // FPU flags are ORed on top of any same-cycle CSR write
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            fcsr_d[w] = fcsr_q[w];
            if (commit && wid == NW_W'(w)) begin
                unique case (dec.kind)
                    K_FFLAGS: fcsr_d[w][4:0] = new_val[4:0];
                    K_FRM:    fcsr_d[w][7:5] = new_val[2:0];
                    K_FCSR:   fcsr_d[w]      = new_val[7:0];
                    default: ;
                endcase
            end
            for (int p = 0; p < NUM_FPU_PORTS; p++)
                if (fpu_valid[p] && fpu_wid[p] == NW_W'(w))
                    fcsr_d[w][4:0] = fcsr_d[w][4:0] | fpu_fflags[p];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_FPU_PORTS; p++)
            fpu_read_frm[p] = fcsr_q[fpu_read_wid[p]][7:5];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                fcsr_q[w]       <= '0;
                shadow_q[w]     <= '0;
                shadow_tag_q[w] <= '0;
                for (int k = 0; k < NUM_SCRATCH; k++)
                    scratch_q[w][k] <= startup_arg;
            end
            for (int k = 0; k < NUM_CTRS; k++)
                ctr_q[k] <= '0;
            shadow_vld_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++)
                fcsr_q[w] <= fcsr_d[w];
            if (commit && dec.kind == K_SCRATCH) begin
                for (int k = 0; k < NUM_SCRATCH; k++)
                    if (dec.index == IDX_W'(k))
                        scratch_q[wid][k] <= new_val[XLEN-1:0];
            end
            // a CSR write to a counter drops that cycle's increment
            for (int k = 0; k < NUM_CTRS; k++) begin
                if (commit && dec.kind == K_CTR && dec.index == IDX_W'(k))
                    ctr_q[k] <= ctr_wr[CTR_BITS-1:0];
                else
                    ctr_q[k] <= ctr_q[k] + CTR_BITS'(ctr_incr[k]);
            end
            if (fire && !err && ctr_sel && XLEN == 32) begin
                if (!dec.hi) begin
                    shadow_q[wid]     <= full64[63:32];
                    shadow_tag_q[wid] <= csr_if.req_addr | CSR_HI_OFS;
                    shadow_vld_q[wid] <= 1'b1;
                end else if (shadow_hit) begin
                    shadow_vld_q[wid] <= 1'b0;
                end
            end
            if (fire) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= err ? '0 : rsp_old[XLEN-1:0];
                rsp_error_q <= err;
            end else if (csr_if.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign csr_if.req_ready = !rsp_valid_q || csr_if.rsp_ready;
    assign csr_if.rsp_valid = rsp_valid_q;
    assign csr_if.rsp_data  = rsp_data_q;
    assign csr_if.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_vx_csr_regfile.sv
// Self-checking bench for vx_csr_regfile (XLEN=32, 4 warps, 44-bit counters).
// Requests push expected responses to a queue; a monitor pops them on transfer.
module tb_vx_csr_regfile;
    import vx_csr_regfile_pkg::*;

    localparam int NW = 4, XL = 32, NSC = 2, NFP = 2, NCT = 4, CB = 44, NW_W = 2;
    localparam logic [CB-1:0] CYC = 44'h0AB_1234_5678;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [XL-1:0]                startup_arg;
    logic [CB-1:0]                cycles;
    logic [NFP-1:0]               fpu_valid;
    logic [NFP-1:0][NW_W-1:0]     fpu_wid;
    logic [NFP-1:0][4:0]          fpu_fflags;
    logic [NFP-1:0][NW_W-1:0]     fpu_read_wid;
    logic [NFP-1:0][2:0]          fpu_read_frm;
    logic [NCT-1:0]               ctr_incr;

    vx_csr_regfile_if #(.NUM_WARPS(NW), .XLEN(XL)) csr_if ();

    vx_csr_regfile #(
        .NUM_WARPS(NW), .XLEN(XL), .NUM_SCRATCH(NSC),
        .NUM_FPU_PORTS(NFP), .NUM_CTRS(NCT), .CTR_BITS(CB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startup_arg  (startup_arg),
        .cycles       (cycles),
        .fpu_valid    (fpu_valid),
        .fpu_wid      (fpu_wid),
        .fpu_fflags   (fpu_fflags),
        .fpu_read_wid (fpu_read_wid),
        .fpu_read_frm (fpu_read_frm),
        .ctr_incr     (ctr_incr),
        .csr_if       (csr_if)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    always @(negedge clk) begin
        if (!reset && csr_if.rsp_valid && csr_if.rsp_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rsp: got data=%h err=%b, required no response",
                         csr_if.rsp_data, csr_if.rsp_error);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (csr_if.rsp_data !== e.d || csr_if.rsp_error !== e.e) begin
                    miscompares++;
                    $display("FAIL %s: got data=%h err=%b, required data=%h err=%b",
                             e.tag, csr_if.rsp_data, csr_if.rsp_error, e.d, e.e);
                end
            end
        end
    end

    task automatic send(input logic [NW_W-1:0] w, input logic [11:0] a,
                        input logic [1:0] op, input logic [31:0] d,
                        input logic [31:0] xd, input logic xe, input string tag);
        int n;
        exp_t e;
        n = 0;
        csr_if.req_valid = 1'b1;
        csr_if.req_wid   = w;
        csr_if.req_addr  = a;
        csr_if.req_op    = op;
        csr_if.req_data  = d;
        @(negedge clk);
        while (!csr_if.req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!csr_if.req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_accept: req_ready=0 after 50 cycles, required 1", tag);
            csr_if.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.d = xd;
            e.e = xe;
            e.tag = tag;
            sb.push_back(e);
            csr_if.req_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", tag, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        startup_arg = 32'h1234;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if (csr_if.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rsp_valid: got %b, required 0", csr_if.rsp_valid);
        end
        vectors++;
        if (csr_if.rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_rsp_data: got %h, required 0", csr_if.rsp_data);
        end
        vectors++;
        if (csr_if.rsp_error !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rsp_error: got %b, required 0", csr_if.rsp_error);
        end
        vectors++;
        if (csr_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_req_ready: got %b, required 1", csr_if.req_ready);
        end
        send(2'd3, CSR_SCRATCH_BASE, CSR_READ, 0, 32'h1234, 1'b0, "scr0_w3");
        vectors++;
        if (csr_if.rsp_valid !== 1'b1 || csr_if.rsp_data !== 32'h1234) begin
            miscompares++;
            $display("FAIL latency1: got valid=%b data=%h, required valid=1 data=1234",
                     csr_if.rsp_valid, csr_if.rsp_data);
        end
        send(2'd0, 12'h341, CSR_WRITE, 32'hCAFE, 32'h1234, 1'b0, "scr1_w0_wr");
        send(2'd0, 12'h341, CSR_READ, 0, 32'hCAFE, 1'b0, "scr1_w0_rd");
        send(2'd2, 12'h341, CSR_READ, 0, 32'h1234, 1'b0, "scr1_w2_rd");
        drain("reset");
    endtask

    task automatic test_fcsr();
        send(2'd1, CSR_FCSR, CSR_WRITE, 32'hE5, 32'h0, 1'b0, "fcsr_wr");
        send(2'd1, CSR_FFLAGS, CSR_SET, 32'h02, 32'h05, 1'b0, "fflags_set");
        send(2'd1, CSR_FRM, CSR_READ, 0, 32'h7, 1'b0, "frm_rd");
        send(2'd1, CSR_FCSR, CSR_READ, 0, 32'hE7, 1'b0, "fcsr_rd");
        drain("fcsr");
        fpu_read_wid[0] = 2'd1;
        fpu_read_wid[1] = 2'd0;
        #1;
        vectors++;
        if (fpu_read_frm[0] !== 3'd7) begin
            miscompares++;
            $display("FAIL frm_port_w1: got %0d, required 7", fpu_read_frm[0]);
        end
        vectors++;
        if (fpu_read_frm[1] !== 3'd0) begin
            miscompares++;
            $display("FAIL frm_port_w0: got %0d, required 0", fpu_read_frm[1]);
        end
        send(2'd1, CSR_FRM, CSR_WRITE, 32'h0A, 32'h7, 1'b0, "frm_wr_mask");
        send(2'd1, CSR_FFLAGS, CSR_CLEAR, 32'h03, 32'h07, 1'b0, "fflags_clr");
        send(2'd1, CSR_FCSR, CSR_READ, 0, 32'h44, 1'b0, "fcsr_rd2");
        drain("fcsr2");
    endtask

    task automatic test_fpu_merge();
        send(2'd2, CSR_FFLAGS, CSR_WRITE, 32'h1F, 32'h0, 1'b0, "ff_w2_preset");
        fpu_valid     = 2'b10;
        fpu_wid[1]    = 2'd2;
        fpu_fflags[1] = 5'h10;
        send(2'd2, CSR_FFLAGS, CSR_WRITE, 32'h0, 32'h1F, 1'b0, "ff_w2_wr0");
        fpu_valid = '0;
        send(2'd2, CSR_FFLAGS, CSR_READ, 0, 32'h10, 1'b0, "ff_w2_merge");
        fpu_valid     = 2'b11;
        fpu_wid[0]    = 2'd3;
        fpu_wid[1]    = 2'd3;
        fpu_fflags[0] = 5'h01;
        fpu_fflags[1] = 5'h04;
        @(posedge clk);
        #1;
        fpu_valid = '0;
        send(2'd3, CSR_FFLAGS, CSR_READ, 0, 32'h05, 1'b0, "ff_w3_two_ports");
        send(2'd0, CSR_FCSR, CSR_READ, 0, 32'h0, 1'b0, "fcsr_w0_untouched");
        drain("fpu");
    endtask

    task automatic test_counter();
        send(2'd0, 12'hB03, CSR_WRITE, 32'hFFFF_FFFF, 32'h0, 1'b0, "c0_lo_wr");
        send(2'd0, 12'hB83, CSR_WRITE, 32'h0, 32'h0, 1'b0, "c0_hi_wr");
        send(2'd0, 12'hB03, CSR_READ, 0, 32'hFFFF_FFFF, 1'b0, "c0_lo_rd");
        ctr_incr = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        ctr_incr = '0;
        send(2'd0, 12'hB83, CSR_READ, 0, 32'h0, 1'b0, "c0_hi_shadow");
        send(2'd0, 12'hB83, CSR_READ, 0, 32'h1, 1'b0, "c0_hi_live");
        send(2'd0, 12'hB03, CSR_READ, 0, 32'h1, 1'b0, "c0_lo_after");
        send(2'd0, 12'hB83, CSR_WRITE, 32'hFFF, 32'h1, 1'b0, "c0_hi_wr2");
        send(2'd0, 12'hB03, CSR_WRITE, 32'hFFFF_FFFF, 32'h1, 1'b0, "c0_lo_wr2");
        ctr_incr = 4'b0001;
        @(posedge clk);
        #1;
        ctr_incr = '0;
        send(2'd0, 12'hB03, CSR_READ, 0, 32'h0, 1'b0, "c0_wrap_lo");
        send(2'd0, 12'hB83, CSR_READ, 0, 32'h0, 1'b0, "c0_wrap_hi");
        ctr_incr = 4'b0010;
        send(2'd1, 12'hB04, CSR_WRITE, 32'h100, 32'h0, 1'b0, "c1_wr");
        ctr_incr = '0;
        send(2'd1, 12'hB04, CSR_READ, 0, 32'h100, 1'b0, "c1_write_wins");
        send(2'd0, CSR_MCYCLE, CSR_READ, 0, 32'h1234_5678, 1'b0, "mcycle");
        send(2'd0, CSR_MCYCLEH, CSR_READ, 0, 32'hAB, 1'b0, "mcycleh");
        drain("counter");
    endtask

    task automatic test_errors();
        send(2'd0, CSR_MCYCLE, CSR_WRITE, 32'h5, 32'h0, 1'b1, "wr_mcycle");
        send(2'd0, 12'h7FF, CSR_READ, 0, 32'h0, 1'b1, "unmapped");
        send(2'd0, CSR_MCYCLE, CSR_CLEAR, 0, 32'h1234_5678, 1'b0, "clr_mcycle_0");
        send(2'd0, CSR_MVENDORID, CSR_SET, 32'h1, 32'h0, 1'b1, "set_mvendorid");
        send(2'd0, CSR_MVENDORID, CSR_READ, 0, 32'h0, 1'b0, "rd_mvendorid");
        send(2'd2, CSR_WARP_ID, CSR_READ, 0, 32'h2, 1'b0, "warp_id");
        send(2'd0, CSR_NUM_WARPS, CSR_READ, 0, 32'h4, 1'b0, "num_warps");
        send(2'd0, 12'h342, CSR_WRITE, 32'h1, 32'h0, 1'b1, "scr_oob");
        send(2'd1, CSR_FCSR, CSR_SET, 32'h0, 32'h44, 1'b0, "set_zero");
        send(2'd0, 12'h341, CSR_READ, 0, 32'hCAFE, 1'b0, "scr_kept");
        drain("errors");
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < NW; w++)
            send(NW_W'(w), CSR_SCRATCH_BASE, CSR_WRITE, 32'h100 + 32'(w),
                 32'h1234, 1'b0, "b2b_preset");
        drain("b2b_preset");
        csr_if.rsp_ready = 1'b0;
        fork
            begin
                for (int w = 0; w < NW; w++)
                    send(NW_W'(w), CSR_SCRATCH_BASE, CSR_READ, 0,
                         32'h100 + 32'(w), 1'b0, "b2b_rd");
            end
        join_none
        @(posedge clk);
        #1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (csr_if.req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_req_ready: got %b, required 0", csr_if.req_ready);
            end
            vectors++;
            if (csr_if.rsp_valid !== 1'b1 || csr_if.rsp_data !== 32'h100) begin
                miscompares++;
                $display("FAIL stall_rsp_hold: got valid=%b data=%h, required valid=1 data=100",
                         csr_if.rsp_valid, csr_if.rsp_data);
            end
        end
        @(posedge clk);
        #1;
        csr_if.rsp_ready = 1'b1;
        wait fork;
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        csr_if.rsp_ready = 1'b0;
        send(2'd1, CSR_FFLAGS, CSR_READ, 0, 32'h04, 1'b0, "pending");
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        vectors++;
        if (csr_if.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_drop: got valid=%b, required 0", csr_if.rsp_valid);
        end
        reset = 1'b0;
        csr_if.rsp_ready = 1'b1;
        send(2'd1, CSR_FCSR, CSR_READ, 0, 32'h0, 1'b0, "fcsr_after_rst");
        send(2'd0, 12'h341, CSR_READ, 0, 32'h1234, 1'b0, "scr_after_rst");
        send(2'd0, 12'hB04, CSR_READ, 0, 32'h0, 1'b0, "ctr_after_rst");
        drain("reset_mid");
    endtask

    initial begin
        csr_if.req_valid = 1'b0;
        csr_if.req_wid   = '0;
        csr_if.req_addr  = '0;
        csr_if.req_data  = '0;
        csr_if.req_op    = '0;
        csr_if.rsp_ready = 1'b1;
        startup_arg  = '0;
        cycles       = CYC;
        fpu_valid    = '0;
        fpu_wid      = '0;
        fpu_fflags   = '0;
        fpu_read_wid = '0;
        ctr_incr     = '0;
        test_reset();
        test_fcsr();
        test_fpu_merge();
        test_counter();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vx_csr_regfile.md
# VX_csr_regfile

Parametrised per-warp CSR register file with a request/response handshake, replacing the flat combinational CSR read/write block.
- Holds per-warp `fcsr`, per-warp scratch registers and a bank of user-writable 64-bit event counters.
- Executes RISC-V CSR read-modify-write ops atomically, returning the old value one cycle later.
- Sits between the SFU CSR issue path and commit, with fflags merged from any number of FPU ports.

## Interface
- `NUM_WARPS`, 4: warps; `NW_W = max(1, clog2(NUM_WARPS))`
- `XLEN`, 32: data width, 32 or 64
- `NUM_SCRATCH`, 2: per-warp scratch CSRs at `CSR_SCRATCH_BASE + k`
- `NUM_FPU_PORTS`, 2: fflags accumulate ports
- `NUM_CTRS`, 4: user counters at `CSR_CTR_BASE + k` (lo), `CSR_CTR_H_BASE + k` (hi)
- `CTR_BITS`, 44: counter width, ≤ 64
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `startup_arg` in XLEN: reset value of every scratch register
- `cycles` in CTR_BITS: free-running cycle count, read-only at MCYCLE/MCYCLEH
- `fpu_valid` in NUM_FPU_PORTS: fflags update strobe per port
- `fpu_wid` in NUM_FPU_PORTS×NW_W: target warp
- `fpu_fflags` in NUM_FPU_PORTS×5: flags to OR in
- `fpu_read_wid` in NUM_FPU_PORTS×NW_W; `fpu_read_frm` out NUM_FPU_PORTS×3: combinational frm lookup
- `ctr_incr` in NUM_CTRS: +1 per set bit per cycle
- `req_valid` in 1, `req_ready` out 1: request handshake
- `req_wid` in NW_W, `req_addr` in 12, `req_data` in XLEN
- `req_op` in 2: 0 READ, 1 WRITE, 2 SET, 3 CLEAR
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake
- `rsp_data` out XLEN: old CSR value
- `rsp_error` out 1: illegal access

## Operation
- Accept on `req_valid & req_ready`; `req_ready = ~rsp_valid | rsp_ready` (single-entry response register, full throughput).
- Per accepted request: decode address, read old value, compute new value (WRITE: `d`; SET: `old|d`; CLEAR: `old&~d`), commit state, load response register.
- SET/CLEAR with `req_data == 0` is a pure read: no state change, never an error.
- Errors, signalled with `rsp_error=1`, `rsp_data=0` and no state change:
  - unmapped address;
  - write-class op to a read-only CSR (MCYCLE*, MVENDORID, WARP_ID, NUM_WARPS);
  - hi-half counter address when `XLEN=64`.
- Per-warp fields: fflags[4:0], frm[7:5]. FFLAGS, FRM and FCSR alias these fields and are masked to their widths.
- Scratch registers are indexed by `req_wid`.
- Counters are shared across warps and writable.
  - `XLEN=32`: lo write replaces bits [31:0]; hi write replaces [CTR_BITS-1:32].
  - `XLEN=64`: full write, truncated to CTR_BITS.
  - Reads are zero-extended to 64 bits.
  - Counters wrap modulo 2^CTR_BITS.
- Coherent hi read (`XLEN=32` only):
  - A lo read of MCYCLE or counter k latches bits [63:32] into a per-warp shadow and sets `shadow_valid[wid]` with the address tag.
  - The next hi read from the same warp with a matching tag returns the shadow and clears `shadow_valid`.
  - Any other hi read returns the live value.
- Simultaneous events:
  - CSR write and FPU flags to the same warp: written value OR that cycle's FPU flags, so no flag is lost.
  - Several FPU ports in the same cycle: all flags are ORed.
  - CSR write and `ctr_incr` on the same counter: the write wins and the increment is dropped.

## Timing
- Response latency is 1 cycle from acceptance. `rsp_valid` holds with stable data until `rsp_ready`.
- A state update is visible to the request accepted in the next cycle (read-after-write with no bubble).
- Reset values:
  - `rsp_valid=0`, `rsp_data=0`, `rsp_error=0`;
  - fcsr=0, counters=0, shadows invalid;
  - scratch=`startup_arg`;
  - `req_ready=1` in the first cycle after reset.
- Reset mid-operation drops any pending response.
- `fpu_read_frm` reflects registered state (0 cycles, pre-update).

## Structure
- Shared package `VX_csr_pkg`:
  - op encoding;
  - address constants: FFLAGS 0x001, FRM 0x002, FCSR 0x003, SCRATCH_BASE 0x340, CTR_BASE 0xB03, CTR_H_BASE 0xB83, MCYCLE 0xB00/0xB80;
  - RMW function;
  - `csr_decode_t` struct (valid, read_only, kind, index, hi).
- One sub-module, `VX_csr_decode`: combinational address→`csr_decode_t`, parametrised by NUM_SCRATCH/NUM_CTRS/XLEN.

## Test plan
- Reset with `startup_arg=0x1234`, READ scratch 0 on warp 3 -> `rsp_data=0x1234`, `rsp_error=0`, one cycle after acceptance.
- WRITE FCSR=0xE5 on warp 1, SET FFLAGS 0x02 -> old 0x05; READ FRM -> 0x7; `fpu_read_frm` for warp 1 = 7; warp 0 remains 0.
- Same cycle: WRITE FFLAGS 0 on warp 2 and FPU port 1 flags 0x10 to warp 2 -> next READ FFLAGS = 0x10.
- XLEN=32: counter 0 preset to 0x0_FFFF_FFFF, lo read, two `ctr_incr` pulses, hi read -> lo 0xFFFFFFFF, hi 0x0 (shadow); second hi read -> 0x1.
- Hold `rsp_ready=0` for 3 cycles with `req_valid=1` -> `req_ready=0` and rsp stable; release -> one transfer per cycle with no lost or duplicated response.
- WRITE to MCYCLE and READ 0x7FF -> `rsp_error=1`, `rsp_data=0`, no state change; CLEAR MCYCLE with data 0 -> no error.
